mul_cic_mc: RTL and testbench



---
 rtl/mul_cic_pkg.sv | 38 +++
 rtl/cic_chan.sv | 74 +++++++
 rtl/mul_cic_mc.sv | 117 +++++++++++
 tb/tb_mul_cic_mc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_cic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_cic_pkg : default sizes and helper functions for mul_cic_mc      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mul_cic_pkg;

  localparam int NCH_DEF   = 2;
  localparam int ORDER_DEF = 5;
  localparam int R_MAX_DEF = 256;

  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int flog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++)
      if (v >= (1 << i)) r = i;
    return r;
  endfunction

  // Word growth of an ORDER-stage CIC at R_MAX, plus sign and headroom.
  function automatic int acc_width(input int order, input int r_max);
    return order * clog2(r_max) + 2;
  endfunction

  function automatic int clamp_ratio(input int d, input int r_max);
    if (d < 2)          return 2;
    else if (d > r_max) return r_max;
    else                return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_chan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cic_chan : one channel of integrators plus pipelined comb stages     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cic_chan
  import mul_cic_pkg::*;
#(
  parameter int ORDER = ORDER_DEF,
  parameter int ACC_W = acc_width(ORDER_DEF, R_MAX_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             in_valid,
  input  logic             dec_evt,
  input  logic [ORDER-1:0] stg_vld,
  output logic [ACC_W-1:0] comb_out
);

  logic [ACC_W-1:0] integ_q [ORDER];
  logic [ACC_W-1:0] integ_d [ORDER];
  logic [ACC_W-1:0] comb_q  [ORDER];
  logic [ACC_W-1:0] comb_d  [ORDER];
  logic [ACC_W-1:0] dly_q   [ORDER];
  logic [ACC_W-1:0] dly_d   [ORDER];
  logic [ACC_W-1:0] stg_in  [ORDER];
  logic [ACC_W-1:0] dec_q, dec_d, sample;

  always_comb begin
    sample = bit_in ? ACC_W'(1) : {ACC_W{1'b1}};
    dec_d  = dec_evt ? integ_q[ORDER-1] : dec_q;
    stg_in[0] = dec_q;
    for (int i = 1; i < ORDER; i++) stg_in[i] = comb_q[i-1];
    for (int i = 0; i < ORDER; i++) begin
      integ_d[i] = integ_q[i];
      comb_d[i]  = comb_q[i];
      dly_d[i]   = dly_q[i];
    end
    // Cascade uses last-cycle values; wrap-around is intentional.
    if (in_valid) begin
      integ_d[0] = integ_q[0] + sample;
      for (int i = 1; i < ORDER; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
    end
    for (int i = 0; i < ORDER; i++) begin
      if (stg_vld[i]) begin
        comb_d[i] = stg_in[i] - dly_q[i];
        dly_d[i]  = stg_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dec_q <= '0;
      for (int i = 0; i < ORDER; i++) begin
        integ_q[i] <= '0;
        comb_q[i]  <= '0;
        dly_q[i]   <= '0;
      end
    end else begin
      dec_q <= dec_d;
      for (int i = 0; i < ORDER; i++) begin
        integ_q[i] <= integ_d[i];
        comb_q[i]  <= comb_d[i];
        dly_q[i]   <= dly_d[i];
      end
    end
  end

  assign comb_out = comb_q[ORDER-1];

endmodule
`default_nettype wire

// File: rtl/mul_cic_mc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_cic_mc : multi-channel CIC decimator for 1-bit sigma-delta input |
// | Optional CIC_GAIN_NORM_EN scales outputs by 1/2^(ORDER*log2(R)).    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mul_cic_mc
  import mul_cic_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int ORDER = ORDER_DEF,
  parameter int R_MAX = R_MAX_DEF,
  parameter int RW    = clog2(R_MAX) + 1,
  parameter int ACC_W = acc_width(ORDER, R_MAX)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       Bit_in,
  input  logic                 In_valid,
  input  logic [RW-1:0]        Dec_ratio,
  output logic [NCH*ACC_W-1:0] Filter_out,
  output logic                 rdy
);

  localparam int WW = clog2(ORDER + 1);

  logic [RW-1:0]        r_eff_q, r_eff_d, r_new, cnt_q, cnt_d;
  logic [WW-1:0]        warm_q, warm_d;
  logic [ORDER:0]       vld_q, vld_d, emit_q, emit_d;
  logic [NCH*ACC_W-1:0] out_q, out_d;
  logic                 rdy_q, rdy_d, evt;
  logic [ACC_W-1:0]     chan_out [NCH];

`ifdef CIC_GAIN_NORM_EN
  localparam int SW = clog2(ORDER * clog2(R_MAX) + 1);
  logic [SW-1:0] sh_q, sh_d;
`endif

  always_comb begin
    r_new   = RW'(clamp_ratio(int'(Dec_ratio), R_MAX));
    evt     = In_valid && (cnt_q == r_eff_q - RW'(1));
    r_eff_d = r_eff_q;
    cnt_d   = cnt_q;
    warm_d  = warm_q;
    out_d   = out_q;
    rdy_d   = 1'b0;
    // Each decimation event carries its own emit tag down the comb pipe.
    vld_d   = {vld_q[ORDER-1:0], evt};
    emit_d  = {emit_q[ORDER-1:0], evt && (warm_q == WW'(ORDER))};
`ifdef CIC_GAIN_NORM_EN
    sh_d = sh_q;
    if (evt && (warm_q == WW'(ORDER))) sh_d = SW'(ORDER * flog2(int'(r_eff_q)));
`endif
    if (In_valid) cnt_d = evt ? '0 : cnt_q + RW'(1);
    if (evt) begin
      r_eff_d = r_new;
      if (r_new != r_eff_q)          warm_d = '0;
      else if (warm_q != WW'(ORDER)) warm_d = warm_q + WW'(1);
    end
    if (vld_q[ORDER] && emit_q[ORDER]) begin
      rdy_d = 1'b1;
      for (int k = 0; k < NCH; k++) begin
`ifdef CIC_GAIN_NORM_EN
        out_d[k*ACC_W +: ACC_W] = $signed(chan_out[k]) >>> sh_q;
`else
        out_d[k*ACC_W +: ACC_W] = chan_out[k];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_eff_q <= r_new;
      cnt_q   <= '0;
      warm_q  <= '0;
      vld_q   <= '0;
      emit_q  <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
`ifdef CIC_GAIN_NORM_EN
      sh_q    <= '0;
`endif
    end else begin
      r_eff_q <= r_eff_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      vld_q   <= vld_d;
      emit_q  <= emit_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
`ifdef CIC_GAIN_NORM_EN
      sh_q    <= sh_d;
`endif
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    cic_chan #(
      .ORDER (ORDER),
      .ACC_W (ACC_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .bit_in   (Bit_in[k]),
      .in_valid (In_valid),
      .dec_evt  (evt),
      .stg_vld  (vld_q[ORDER-1:0]),
      .comb_out (chan_out[k])
    );
  end

  assign Filter_out = out_q;
  assign rdy        = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_cic_mc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mul_cic_mc : directed vector bench for mul_cic_mc                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mul_cic_mc;

  localparam int NCH = 2, ORDER = 5, R_MAX = 256, RW = 9, ACC_W = 42;

  logic                 clk = 1'b0, rst = 1'b0, In_valid = 1'b0;
  logic [NCH-1:0]       Bit_in = '0;
  logic [RW-1:0]        Dec_ratio = 9'd64;
  logic [NCH*ACC_W-1:0] Filter_out;
  logic                 rdy;

  mul_cic_mc #(
    .NCH(NCH), .ORDER(ORDER), .R_MAX(R_MAX), .RW(RW), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .Bit_in(Bit_in), .In_valid(In_valid),
    .Dec_ratio(Dec_ratio), .Filter_out(Filter_out), .rdy(rdy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint ch(input int k);
    return longint'($signed(Filter_out[k*ACC_W +: ACC_W]));
  endfunction

  int     n_rdy = 0, last_rdy_cyc = 0, prev_rdy_cyc = 0;
  longint last0 = 0, last1 = 0;
  always @(negedge clk) begin
    if (rdy) begin
      n_rdy++;
      prev_rdy_cyc = last_rdy_cyc;
      last_rdy_cyc = cyc;
      last0 = ch(0);
      last1 = ch(1);
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected value picker: raw CIC result or gain-normalised result.
  function automatic longint ev(input longint raw, input longint nrm);
`ifdef CIC_GAIN_NORM_EN
    return nrm;
`else
    return raw;
`endif
  endfunction

  function automatic logic pat(input int m, input int i);
    if (m == 1) return 1'b1;
    if (m == 2) return (i % 2 == 0);
    return 1'b0;
  endfunction

  int last_v_cyc = 0;
  task automatic drive(input int n, input int gap, input int m0, input int m1);
    for (int i = 0; i < n; i++) begin
      Bit_in   = {pat(m1, i), pat(m0, i)};
      In_valid = 1'b1;
      @(posedge clk); #1;
      last_v_cyc = cyc;
      In_valid = 1'b0;
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    In_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode: 0 = all zeros, 1 = all ones, 2 = alternating 1/0
  typedef struct {
    int     dec;
    int     r;
    int     m0;
    int     m1;
    int     gap;
    int     nev;
    int     nrdy;
    longint e0;
    longint e1;
    longint n0;
    longint n1;
  } vec_t;

  vec_t vt [6];
  int   base;

  initial begin
    vt[0] = '{64,  64,  1, 1, 1,  8, 3,  64'sd1073741824,  64'sd1073741824,  1,  1};
    vt[1] = '{64,  64,  0, 2, 2,  7, 2, -64'sd1073741824,  0,               -1,  0};
    vt[2] = '{0,   2,   1, 1, 98, 8, 3,  32,               32,               1,  1};
    vt[3] = '{300, 256, 1, 0, 1,  7, 2,  64'sd1099511627776, -64'sd1099511627776, 1, -1};
    vt[4] = '{1,   2,   2, 1, 1,  10, 5, 0,                32,               0,  1};
    vt[5] = '{3,   3,   1, 0, 1,  8, 3,  243,              -243,             7, -8};

    for (int v = 0; v < 6; v++) begin
      Dec_ratio = RW'(vt[v].dec);
      do_reset();
      base = n_rdy;
      drive(vt[v].nev * vt[v].r, vt[v].gap, vt[v].m0, vt[v].m1);
      settle(ORDER + 4);
      check($sformatf("v%0d rdy_count", v), longint'(n_rdy - base), longint'(vt[v].nrdy));
      check($sformatf("v%0d ch0_at_rdy", v), last0, ev(vt[v].e0, vt[v].n0));
      check($sformatf("v%0d ch1_at_rdy", v), last1, ev(vt[v].e1, vt[v].n1));
      check($sformatf("v%0d ch0_hold", v), ch(0), ev(vt[v].e0, vt[v].n0));
    end

    // Reset clears the output word.
    do_reset();
    check("reset ch0", ch(0), 0);
    check("reset ch1", ch(1), 0);
    check("reset rdy", longint'(rdy), 0);

    // Latency from accepted decimation event to rdy.
    Dec_ratio = 9'd2;
    do_reset();
    base = n_rdy;
    drive(12, 4, 1, 1);
    settle(12);
    check("lat rdy_count", longint'(n_rdy - base), 1);
    check("lat clks", longint'(last_rdy_cyc - last_v_cyc), longint'(ORDER + 1));
    check("lat ch0", last0, ev(32, 1));

    // Ratio change mid-frame takes effect at the next boundary.
    Dec_ratio = 9'd64;
    do_reset();
    drive(8 * 64, 1, 1, 1);
    settle(10);
    base = n_rdy;
    drive(10, 1, 1, 1);
    Dec_ratio = 9'd32;
    drive(54, 1, 1, 1);
    settle(10);
    check("chg old_frame count", longint'(n_rdy - base), 1);
    check("chg old_frame ch0", last0, ev(64'sd1073741824, 1));
    base = n_rdy;
    drive(6 * 32, 1, 1, 1);
    settle(10);
    check("chg warmup count", longint'(n_rdy - base), 1);
    check("chg new ch1", last1, ev(64'sd33554432, 1));
    base = n_rdy;
    drive(2 * 32, 2, 1, 1);
    settle(10);
    check("chg steady count", longint'(n_rdy - base), 2);
    check("chg rdy spacing", longint'(last_rdy_cyc - prev_rdy_cyc), 64);

    // One-clk reset while an emitting event is still in the comb pipe.
    Dec_ratio = 9'd2;
    do_reset();
    base = n_rdy;
    drive(12, 1, 1, 1);
    repeat (ORDER - 1) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    settle(10);
    check("midrst rdy_count", longint'(n_rdy - base), 0);
    check("midrst ch0", ch(0), 0);
    check("midrst ch1", ch(1), 0);
    base = n_rdy;
    drive(10, 1, 1, 1);
    settle(10);
    check("midrst warmup count", longint'(n_rdy - base), 0);
    drive(2, 1, 1, 1);
    settle(10);
    check("midrst after count", longint'(n_rdy - base), 1);
    check("midrst after ch0", last0, ev(32, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
